// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle for the register-file target: controller drives nCS/SCLK/COPI,
// target drives CIPO/CIPO_oe.
interface spi_regfile_peripheral_if;
    logic nCS;
    logic SCLK;
    logic COPI;
    logic CIPO;
    logic CIPO_oe;

    modport master (output nCS, output SCLK, output COPI, input CIPO, input CIPO_oe);
    modport slave  (input nCS, input SCLK, input COPI, output CIPO, output CIPO_oe);
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target with a parametrised register file, write and read-back.
// Optional saturating error counter readable at address NUM_REGS: SPI_REGFILE_ERR_CNT_EN.
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_regfile_peripheral_if.slave    spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [1:0]                 state_dbg
);
    // Handshake: wr_strobe is a single-cycle pulse with no backpressure; wr_addr and
    // the updated regs_flat are both valid in the same cycle wr_strobe is high.

    localparam int L   = 1 + ADDR_W + DATA_W;
    localparam int CW  = $clog2(L + 2);
    localparam int RXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [CW-1:0]     L_C   = CW'(L);
    localparam logic [CW-1:0]     HDR_C = CW'(1 + ADDR_W);
    localparam logic [CW-1:0]     SAT_C = CW'(L + 1);
    localparam logic [ADDR_W-1:0] NR_A  = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] ncs_sync, sclk_sync, copi_sync;
    logic ncs_d, sclk_d;
    logic ncs_s, sclk_s, copi_s;
    logic ncs_rise, sclk_rise, sclk_fall;
    logic [CW-1:0]     bit_cnt;
    logic [RXW-1:0]    rx;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic              wr_ok;
`ifdef SPI_REGFILE_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign wr_ok     = rw_q && (bit_cnt == L_C) && (addr_q < NR_A);

    assign spi.CIPO    = (state == DATA) && tx[DATA_W-1];
    assign spi.CIPO_oe = ~ncs_s;
    assign state_dbg   = state;

    // Read mux keyed on the address bits just shifted in during the header.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rx[ADDR_W-1:0] == ADDR_W'(r))
                rd_data = regs_flat[r*DATA_W +: DATA_W];
        end
`ifdef SPI_REGFILE_ERR_CNT_EN
        if (rx[ADDR_W-1:0] == NR_A)
            rd_data = DATA_W'(err_cnt);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ncs_sync  <= '1;
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_d     <= 1'b1;
            sclk_d    <= 1'b0;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            regs_flat <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
`ifdef SPI_REGFILE_ERR_CNT_EN
            err_cnt   <= '0;
`endif
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.nCS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.COPI};
            ncs_d     <= ncs_s;
            sclk_d    <= sclk_s;
            wr_strobe <= 1'b0;

            // nCS rising outranks any SCLK edge seen in the same cycle.
            if (ncs_rise) begin
                state <= (state == CMD || state == DATA) ? COMMIT : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        // Level check so a select that fell during COMMIT is still honoured.
                        if (!ncs_s) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                            rx      <= '0;
                            tx      <= '0;
                            addr_q  <= '0;
                            rw_q    <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (bit_cnt == HDR_C) begin
                            addr_q <= rx[ADDR_W-1:0];
                            tx     <= rw_q ? '0 : rd_data;
                            state  <= DATA;
                        end else if (sclk_rise) begin
                            rx <= {rx[RXW-2:0], copi_s};
                            if (bit_cnt == '0) rw_q <= copi_s;
                            if (bit_cnt != SAT_C) bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            rx <= {rx[RXW-2:0], copi_s};
                            if (bit_cnt != SAT_C) bit_cnt <= bit_cnt + CW'(1);
                        end else if (sclk_fall && bit_cnt > HDR_C) begin
                            tx <= {tx[DATA_W-2:0], 1'b0};
                        end
                    end
                    COMMIT: begin
                        if (wr_ok) begin
                            for (int r = 0; r < NUM_REGS; r++) begin
                                if (addr_q == ADDR_W'(r))
                                    regs_flat[r*DATA_W +: DATA_W] <= rx[DATA_W-1:0];
                            end
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr_q;
                        end
`ifdef SPI_REGFILE_ERR_CNT_EN
                        if (rw_q && !wr_ok && err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
`endif
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral: default instance plus a
// NUM_REGS=3/ADDR_W=4/DATA_W=16 instance sharing the SPI stimulus lines.
module tb_spi_regfile_peripheral;
    localparam int HALF = 8;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic ncs = 1'b1, sclk = 1'b0, copi = 1'b0;
    int   tgt = 0;

    spi_regfile_peripheral_if bus0();
    spi_regfile_peripheral_if bus1();
    assign bus0.nCS  = (tgt == 0) ? ncs : 1'b1;
    assign bus0.SCLK = sclk;
    assign bus0.COPI = copi;
    assign bus1.nCS  = (tgt == 1) ? ncs : 1'b1;
    assign bus1.SCLK = sclk;
    assign bus1.COPI = copi;

    logic [63:0] regs_flat0;
    logic        wr_strobe0;
    logic [6:0]  wr_addr0;
    logic [1:0]  state0;
    logic [47:0] regs_flat1;
    logic        wr_strobe1;
    logic [3:0]  wr_addr1;
    logic [1:0]  state1;

    spi_regfile_peripheral u_dut (
        .clk(clk), .rst(rst), .spi(bus0),
        .regs_flat(regs_flat0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .state_dbg(state0)
    );

    spi_regfile_peripheral #(.NUM_REGS(3), .ADDR_W(4), .DATA_W(16), .SYNC_STAGES(SYNC)) u_dut2 (
        .clk(clk), .rst(rst), .spi(bus1),
        .regs_flat(regs_flat1), .wr_strobe(wr_strobe1), .wr_addr(wr_addr1), .state_dbg(state1)
    );

    logic cipo, cipo_oe;
    assign cipo    = (tgt == 1) ? bus1.CIPO : bus0.CIPO;
    assign cipo_oe = (tgt == 1) ? bus1.CIPO_oe : bus0.CIPO_oe;

    // ---------------- reference model ----------------
    function automatic int f_nr(input int t);  return (t == 1) ? 3 : 8;   endfunction
    function automatic int f_aw(input int t);  return (t == 1) ? 4 : 7;   endfunction
    function automatic int f_dw(input int t);  return (t == 1) ? 16 : 8;  endfunction
    function automatic int f_len(input int t); return 1 + f_aw(t) + f_dw(t); endfunction

    logic [15:0] mdl [2][8];
    int          err_c [2];
    logic [31:0] exp_q[$];
    logic [31:0] rd_exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic logic [63:0] model_flat(input int t);
        logic [63:0] f = '0;
        for (int r = 0; r < f_nr(t); r++)
            f = f | (64'(mdl[t][r]) << (r * f_dw(t)));
        return f;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < 2; t++) begin
            err_c[t] = 0;
            for (int r = 0; r < 8; r++) mdl[t][r] = '0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic send_frame(input logic [31:0] bits, input int nbits, input int gap, input int rst_at);
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            copi = bits[nbits-1-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ncs  = 1'b1;
        copi = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic issue(input int t, input logic [31:0] bits, input int nbits, input int gap);
        int unsigned addr, data;
        logic        rw;
        logic [15:0] rdv;
        tgt  = t;
        rw   = bits[nbits-1];
        addr = (bits >> f_dw(t)) & ((32'd1 << f_aw(t)) - 1);
        data = bits & ((32'd1 << f_dw(t)) - 1);
        if (rw) begin
            if (nbits == f_len(t) && addr < f_nr(t)) begin
                mdl[t][addr] = 16'(data);
                exp_q.push_back({t[0], 15'(addr), 16'(data)});
            end else if (err_c[t] < 255) begin
                err_c[t]++;
            end
        end else if (nbits == f_len(t)) begin
            rdv = (addr < f_nr(t)) ? mdl[t][addr] : 16'h0;
`ifdef SPI_REGFILE_ERR_CNT_EN
            if (addr == f_nr(t)) rdv = 16'(err_c[t]) & 16'((32'd1 << f_dw(t)) - 1);
`endif
            rd_exp_q.push_back({t[0], 15'(addr), rdv});
        end
        send_frame(bits, nbits, gap, -1);
        chk("cipo_oe_idle", {63'd0, cipo_oe}, 64'd0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : strobe_mon
        logic [31:0] act;
        logic [31:0] e;
        if (!rst && (wr_strobe0 || wr_strobe1)) begin
            if (wr_strobe1)
                act = {1'b1, 11'd0, wr_addr1, regs_flat1[wr_addr1*16 +: 16]};
            else
                act = {1'b0, 8'd0, wr_addr0, 8'd0, regs_flat0[wr_addr0*8 +: 8]};
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", {32'd0, act}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_commit", {32'd0, act}, {32'd0, e});
            end
        end
    end

    logic        ncs_last = 1'b1;
    int          rm_cnt = 0;
    logic        rm_rw = 1'b0;
    logic [15:0] rm_hdr = '0, rm_data = '0;

    always @(posedge sclk or ncs) begin : read_mon
        logic [31:0] e;
        if (ncs !== ncs_last) begin
            ncs_last = ncs;
            if (!ncs) begin
                rm_cnt  = 0;
                rm_hdr  = '0;
                rm_data = '0;
            end else if (rm_cnt == f_len(tgt) && !rm_rw) begin
                if (rd_exp_q.size() == 0) begin
                    chk("read_unexpected", 64'd1, 64'd0);
                end else begin
                    e = rd_exp_q.pop_front();
                    chk("read_data", {32'd0, tgt[0], 15'(rm_hdr & 16'((32'd1 << f_aw(tgt)) - 1)), rm_data},
                        {32'd0, e});
                end
            end
        end else if (sclk && !ncs) begin
            chk("cipo_oe_active", {63'd0, cipo_oe}, 64'd1);
            if (rm_cnt == 0)            rm_rw   = copi;
            else if (rm_cnt <= f_aw(tgt)) rm_hdr  = {rm_hdr[14:0], copi};
            else                        rm_data = {rm_data[14:0], cipo};
            rm_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_regs0",   regs_flat0, 64'd0);
        chk("reset_regs1",   {16'd0, regs_flat1}, 64'd0);
        chk("reset_cipo",    {63'd0, cipo}, 64'd0);
        chk("reset_oe",      {63'd0, cipo_oe}, 64'd0);
        chk("reset_strobe",  {62'd0, wr_strobe1, wr_strobe0}, 64'd0);
        chk("reset_wr_addr", {53'd0, wr_addr1, wr_addr0}, 64'd0);
        chk("reset_state",   {60'd0, state1, state0}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(0, 32'h803C, 16, 10);
        chk("single_write_regs", regs_flat0, model_flat(0));

        issue(0, 32'h84A5, 16, 10);
        issue(0, 32'h0400, 16, 10);

        issue(0, 32'h8977, 16, 10);
        issue(0, 32'h8155 >> 1, 15, 10);
        issue(0, 32'h0800, 16, 10);
        chk("discard_regs", regs_flat0, model_flat(0));

        issue(0, 32'h8211, 16, SYNC + 2);
        issue(0, 32'h8322, 16, 10);
        chk("back_to_back_regs", regs_flat0, model_flat(0));

        for (int k = 0; k < 40; k++) begin
            logic [31:0] full;
            int nb, ex;
            full = {16'h0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 10)), 8'($urandom_range(0, 255))};
            nb = 16;
            case ($urandom_range(0, 5))
                0: begin ex = $urandom_range(1, 4); nb = 16 - ex; full = full >> ex; end
                1: begin ex = $urandom_range(1, 3); nb = 16 + ex;
                         full = (full << ex) | 32'($urandom_range(0, (1 << ex) - 1)); end
                default: nb = 16;
            endcase
            issue(0, full, nb, $urandom_range(4, 12));
        end
        chk("random_regs", regs_flat0, model_flat(0));

        issue(1, 32'h12BEEF, 21, 10);
        chk("wide_slot2", {48'd0, regs_flat1[47:32]}, 64'hBEEF);
        chk("wide_regs", {16'd0, regs_flat1}, model_flat(1));
        issue(1, 32'h020000, 21, 10);

        tgt = 0;
        send_frame(32'h805A, 16, 10, 10);
        model_clear();
        chk("rst_abort_regs0", regs_flat0, 64'd0);
        chk("rst_abort_regs1", {16'd0, regs_flat1}, 64'd0);
        chk("rst_abort_idle",  {62'd0, state0}, 64'd0);

        issue(0, 32'h8766, 16, 10);
        issue(0, 32'h0700, 16, 10);

        repeat (20) @(negedge clk);
        chk("strobe_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("read_queue_empty", 64'(rd_exp_q.size()), 64'd0);
        chk("final_regs0", regs_flat0, model_flat(0));
        chk("final_regs1", {16'd0, regs_flat1}, model_flat(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
